alu_serial: RTL and testbench

Parametrised, slice-serial ALU/shift unit for the sm83 core and its wider derivatives. It processes a `WIDTH`-bit operation `SLICE` bits per cycle, LSB slice first, which mirrors the SM83's 4-bit ALU datapath. The start/busy/done handshake lets the sequencer stall on multi-cycle results. It adds the full CB-prefix shift/rotate set, SWAP and an optional DAA; the single-cycle combinational ALU/SRU pair does not have these.

---
 rtl/alu_serial.sv | 168 ++++++++++++++++
 tb/tb_alu_serial.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/alu_serial.sv
// Slice-serial ALU/shift unit: arithmetic/logic ops run SLICE bits per cycle, LSB first;
// shifts, SWAP and (with ALU_SERIAL_DAA_EN) DAA complete in a single RUN cycle.
module alu_serial #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] arg,
  input  logic [3:0]       f_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       f_out,
  output logic             illegal
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int HSLICE = 3 / SLICE;  // slice holding bit 3 (half-carry source)
  localparam int HBIT   = 3 % SLICE;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [KW-1:0]    k;
  logic             cy, h_r, ill_r;
  logic [WIDTH-1:0] a_r, b_r, wres;
  logic [3:0]       fin_r;
  logic [4:0]       op_r;

  logic             accept, last, sub, cin, c_rip, h_bit;
  logic [SLICE-1:0] sa, sb_raw, sb, s_sum, s_res;
  logic [WIDTH-1:0] w_nx, sh_res, fin_res;
  logic             sh_c, fin_ill;
  logic [3:0]       fin_f;
  logic [7:0]       d8, corr;
  logic             dc;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (op_r >= 5'd8) || (k == KW'(NSLICE - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign illegal = done && ill_r;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One slice of the add/logic datapath plus the full-word single-cycle ops.
  always_comb begin
    sub    = (op_r == 5'd2) || (op_r == 5'd3) || (op_r == 5'd7);
    sa     = a_r[k*SLICE +: SLICE];
    sb_raw = b_r[k*SLICE +: SLICE];
    sb     = sub ? ~sb_raw : sb_raw;
    if (k != '0)            cin = cy;
    else if (op_r == 5'd1)  cin = fin_r[0];
    else if (op_r == 5'd3)  cin = ~fin_r[0];
    else                    cin = sub;
    c_rip = cin;
    h_bit = h_r;
    s_sum = '0;
    for (int i = 0; i < SLICE; i++) begin
      s_sum[i] = sa[i] ^ sb[i] ^ c_rip;
      c_rip    = (sa[i] & sb[i]) | (c_rip & (sa[i] ^ sb[i]));
      if (int'(k) == HSLICE && i == HBIT) h_bit = c_rip;
    end
    case (op_r)
      5'd4:    s_res = sa & sb_raw;
      5'd5:    s_res = sa ^ sb_raw;
      5'd6:    s_res = sa | sb_raw;
      default: s_res = s_sum;
    endcase
    w_nx = wres;
    w_nx[k*SLICE +: SLICE] = s_res;

    sh_res = a_r;
    sh_c   = 1'b0;
    case (op_r)
      5'd8:  begin sh_res = {a_r[WIDTH-2:0], a_r[WIDTH-1]}; sh_c = a_r[WIDTH-1]; end
      5'd9:  begin sh_res = {a_r[0], a_r[WIDTH-1:1]};       sh_c = a_r[0];       end
      5'd10: begin sh_res = {a_r[WIDTH-2:0], fin_r[0]};     sh_c = a_r[WIDTH-1]; end
      5'd11: begin sh_res = {fin_r[0], a_r[WIDTH-1:1]};     sh_c = a_r[0];       end
      5'd12: begin sh_res = {a_r[WIDTH-2:0], 1'b0};         sh_c = a_r[WIDTH-1]; end
      5'd13: begin sh_res = {a_r[WIDTH-1], a_r[WIDTH-1:1]}; sh_c = a_r[0];       end
      5'd14: sh_res = {a_r[WIDTH/2-1:0], a_r[WIDTH-1:WIDTH/2]};
      5'd15: begin sh_res = {1'b0, a_r[WIDTH-1:1]};         sh_c = a_r[0];       end
      default: ;
    endcase

    d8   = a_r[7:0];
    dc   = fin_r[0];
    corr = '0;

    fin_res = w_nx;
    fin_f   = '0;
    fin_ill = 1'b0;
    case (op_r)
      5'd0, 5'd1, 5'd2, 5'd3:
        fin_f = {(w_nx == '0), sub, sub ^ h_bit, sub ^ c_rip};
      5'd7: begin
        fin_res = a_r;
        fin_f   = {(w_nx == '0), 1'b1, ~h_bit, ~c_rip};
      end
      5'd4:       fin_f = {(w_nx == '0), 3'b010};
      5'd5, 5'd6: fin_f = {(w_nx == '0), 3'b000};
      5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15: begin
        fin_res = sh_res;
        fin_f   = {(sh_res == '0), 2'b00, sh_c};
      end
`ifdef ALU_SERIAL_DAA_EN
      5'd16: begin
        if (!fin_r[2]) begin
          if (fin_r[0] || d8 > 8'h99) begin corr[6:5] = 2'b11; dc = 1'b1; end
          if (fin_r[1] || d8[3:0] > 4'h9) corr[2:1] = 2'b11;
          fin_res = a_r;
          fin_res[7:0] = d8 + corr;
        end else begin
          if (fin_r[0]) corr[6:5] = 2'b11;
          if (fin_r[1]) corr[2:1] = 2'b11;
          fin_res = a_r;
          fin_res[7:0] = d8 - corr;
        end
        fin_f = {(fin_res == '0), fin_r[2], 1'b0, dc};
      end
`endif
      default: begin
        fin_res = a_r;
        fin_f   = fin_r;
        fin_ill = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k <= '0; cy <= 1'b0; h_r <= 1'b0; ill_r <= 1'b0;
      a_r <= '0; b_r <= '0; wres <= '0; fin_r <= '0; op_r <= '0;
      res <= '0; f_out <= '0;
    end else if (accept) begin
      a_r <= acc; b_r <= arg; fin_r <= f_in; op_r <= op;
      k <= '0; cy <= 1'b0; h_r <= 1'b0; wres <= '0;
    end else if (state == RUN) begin
      k    <= k + KW'(1);
      cy   <= c_rip;
      h_r  <= h_bit;
      wres <= w_nx;
      if (last) begin
        res   <= fin_res;
        f_out <= fin_f;
        ill_r <= fin_ill;
      end
    end
  end
endmodule

// File: tb/tb_alu_serial.sv
// Directed bench for alu_serial: an 8-bit and a 16-bit instance, hand-computed vectors.
module tb_alu_serial;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8 = 1'b1, s8 = 1'b0, busy8, done8, ill8;
  logic [4:0]  op8 = '0;
  logic [7:0]  acc8 = '0, arg8 = '0, res8;
  logic [3:0]  fin8 = '0, f8;
  logic        rst16 = 1'b1, s16 = 1'b0, busy16, done16, ill16;
  logic [4:0]  op16 = '0;
  logic [15:0] acc16 = '0, arg16 = '0, res16;
  logic [3:0]  fin16 = '0, f16;

  int n_chk = 0, n_pass = 0;

  alu_serial #(.WIDTH(8), .SLICE(4)) u8 (
    .clk(clk), .rst(rst8), .start(s8), .op(op8), .acc(acc8), .arg(arg8), .f_in(fin8),
    .busy(busy8), .done(done8), .res(res8), .f_out(f8), .illegal(ill8));

  alu_serial #(.WIDTH(16), .SLICE(4)) u16 (
    .clk(clk), .rst(rst16), .start(s16), .op(op16), .acc(acc16), .arg(arg16), .f_in(fin16),
    .busy(busy16), .done(done16), .res(res16), .f_out(f16), .illegal(ill16));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic run8(input string tag, input logic [4:0] o, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] f, input logic [7:0] er, input logic [3:0] ef,
                      input logic eill, input int ecyc);
    int cyc, bcnt;
    s8 = 1'b1; op8 = o; acc8 = a; arg8 = b; fin8 = f;
    cyc = 0; bcnt = 0;
    do begin
      @(negedge clk); s8 = 1'b0; cyc++;
      if (busy8) bcnt++;
    end while (!done8 && cyc < 20);
    chk({tag, "_cyc"}, cyc, ecyc);
    chk({tag, "_busy"}, bcnt, ecyc - 1);
    chk({tag, "_res"}, res8, er);
    chk({tag, "_f"}, f8, ef);
    chk({tag, "_ill"}, ill8, eill);
  endtask

  task automatic run16(input string tag, input logic [4:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] f, input logic [15:0] er, input logic [3:0] ef, input int ecyc);
    int cyc;
    s16 = 1'b1; op16 = o; acc16 = a; arg16 = b; fin16 = f;
    cyc = 0;
    do begin
      @(negedge clk); s16 = 1'b0; cyc++;
    end while (!done16 && cyc < 20);
    chk({tag, "_cyc"}, cyc, ecyc);
    chk({tag, "_res"}, res16, er);
    chk({tag, "_f"}, f16, ef);
  endtask

  initial begin
    int cyc, dcnt, d1, d2;
    repeat (2) @(negedge clk);
    rst8 = 1'b0; rst16 = 1'b0;
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_res", res8, 8'h00);
    chk("rst_f", f8, 4'h0);
    chk("rst_ill", ill8, 1'b0);

    run8("add",  5'd0,  8'h3A, 8'hC6, 4'h0, 8'h00, 4'hB, 1'b0, 3);
    run8("cp",   5'd7,  8'h42, 8'h42, 4'h0, 8'h42, 4'hC, 1'b0, 3);
    run8("rr",   5'd11, 8'h01, 8'h00, 4'h1, 8'h80, 4'h1, 1'b0, 2);
    run8("and",  5'd4,  8'hF0, 8'h3C, 4'h0, 8'h30, 4'h2, 1'b0, 3);
    run8("xor",  5'd5,  8'hAA, 8'hAA, 4'h0, 8'h00, 4'h8, 1'b0, 3);
    run8("adc",  5'd1,  8'h0F, 8'h00, 4'h1, 8'h10, 4'h2, 1'b0, 3);
    run8("swap", 5'd14, 8'hA5, 8'h00, 4'hF, 8'h5A, 4'h0, 1'b0, 2);
    run8("sra",  5'd13, 8'h81, 8'h00, 4'h0, 8'hC0, 4'h1, 1'b0, 2);
    run8("sla",  5'd12, 8'h80, 8'h00, 4'h0, 8'h00, 4'h9, 1'b0, 2);
    run8("rlc",  5'd8,  8'h80, 8'h00, 4'h0, 8'h01, 4'h1, 1'b0, 2);
    run8("srl",  5'd15, 8'h01, 8'h00, 4'h0, 8'h00, 4'h9, 1'b0, 2);
    run8("ill",  5'd20, 8'h5A, 8'h00, 4'hB, 8'h5A, 4'hB, 1'b1, 2);
    run8("add2", 5'd0,  8'h45, 8'h38, 4'h0, 8'h7D, 4'h0, 1'b0, 3);
`ifdef ALU_SERIAL_DAA_EN
    run8("daa",  5'd16, 8'h7D, 8'h00, 4'h0, 8'h83, 4'h0, 1'b0, 2);
`else
    run8("op16", 5'd16, 8'h7D, 8'h00, 4'h5, 8'h7D, 4'h5, 1'b1, 2);
`endif

    // start held: second op accepted only in the DONE cycle
    @(negedge clk);
    s8 = 1'b1; op8 = 5'd0; acc8 = 8'h01; arg8 = 8'h01; fin8 = 4'h0;
    dcnt = 0; d1 = 0; d2 = 0;
    for (cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      if (done8) begin dcnt++; if (dcnt == 1) d1 = cyc; else d2 = cyc; end
      if (cyc == 6) s8 = 1'b0;
    end
    chk("held_cnt", dcnt, 2);
    chk("held_d1", d1, 3);
    chk("held_d2", d2, 6);
    chk("held_res", res8, 8'h02);

    // start pulses during RUN are ignored
    s8 = 1'b1; op8 = 5'd0; acc8 = 8'h03; arg8 = 8'h04;
    dcnt = 0; d1 = 0;
    for (cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (done8) begin dcnt++; d1 = cyc; end
      s8 = (cyc <= 2);
    end
    chk("pulse_cnt", dcnt, 1);
    chk("pulse_d1", d1, 3);
    chk("pulse_res", res8, 8'h07);

    run16("sub16", 5'd2, 16'h1000, 16'h0001, 4'h0, 16'h0FFF, 4'h6, 5);
    run16("sbc16", 5'd3, 16'h0000, 16'h0000, 4'h1, 16'hFFFF, 4'h7, 5);
    run16("add16", 5'd0, 16'h0FFF, 16'h0001, 4'h0, 16'h1000, 4'h2, 5);

    // reset asserted in cycle 1 of an ADD aborts it
    s16 = 1'b1; op16 = 5'd0; acc16 = 16'h1234; arg16 = 16'h1111; fin16 = 4'h0;
    @(negedge clk);
    s16 = 1'b0; rst16 = 1'b1;
    chk("abort_busy_c1", busy16, 1'b1);
    @(negedge clk);
    chk("abort_busy", busy16, 1'b0);
    chk("abort_res", res16, 16'h0000);
    chk("abort_f", f16, 4'h0);
    rst16 = 1'b0;
    dcnt = 0;
    for (cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (done16) dcnt++;
    end
    chk("abort_nodone", dcnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
